// File: rtl/lfsr5_checker.sv
// lfsr5_checker: receive-side checker for the 5-bit maximal-length LFSR stream
// (next(p) = {p[2]^p[0], p[4:1]}, period 31, all-zero illegal).
// The checker hunts for a seed word, then needs LOCK_CNT consecutive correct
// successors before it declares lock. While locked, it predicts each word from
// its own reference, so a single corrupted word costs exactly one error.
// Optional feature macro: LFSR5_CHK_CLR_EN adds the err_clr input, which
// synchronously clears err_count.
module lfsr5_checker #(
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_ERRS = 3,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             preset,
`ifdef LFSR5_CHK_CLR_EN
    input  logic             err_clr,
`endif
    input  logic             in_valid,
    input  logic [4:0]       in_data,
    output logic             locked,
    output logic             err,
    output logic             zero_seen,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_ERRS);

    state_t           state_q, state_d;
    logic [4:0]       exp_q, exp_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic             locked_q;
    logic             err_q, err_d;
    logic             zero_q, zero_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [4:0]       pred;
    logic             is_zero;

    function automatic logic [4:0] lfsr_next(input logic [4:0] p);
        return {p[2] ^ p[0], p[4:1]};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    assign pred    = lfsr_next(exp_q);
    assign is_zero = (in_data == 5'd0);

    // Next-state, counter and pulse logic for one accepted word
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        run_d   = run_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        zero_d  = 1'b0;
        cnt_d   = cnt_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (is_zero) begin
                        zero_d = 1'b1;
                    end else begin
                        exp_d   = in_data;
                        run_d   = 4'd0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (is_zero) begin
                        zero_d  = 1'b1;
                        state_d = HUNT;
                    end else if (in_data == pred) begin
                        exp_d = in_data;
                        run_d = run_q + 4'd1;
                        if ((run_q + 4'd1) == LOCK_N) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        // Reseed on the received word: it may be the true stream
                        exp_d = in_data;
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    // Free-run the reference so corruption never propagates
                    exp_d = pred;
                    if (in_data == pred) begin
                        miss_d = 4'd0;
                    end else begin
                        err_d  = 1'b1;
                        zero_d = is_zero;
                        cnt_d  = sat_inc(cnt_q);
                        miss_d = miss_q + 4'd1;
                        if ((miss_q + 4'd1) == UNLOCK_N) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
`ifdef LFSR5_CHK_CLR_EN
        // Clear wins over a coincident error; the err pulse is unaffected
        if (err_clr) begin
            cnt_d = '0;
        end
`endif
    end

    // State, reference and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (preset) begin
            state_q  <= HUNT;
            exp_q    <= 5'b11111;
            run_q    <= 4'd0;
            miss_q   <= 4'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            run_q    <= run_d;
            miss_q   <= miss_d;
            locked_q <= (state_d == LOCKED);
            err_q    <= err_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign zero_seen = zero_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_lfsr5_checker.sv
// tb_lfsr5_checker: drives two checkers (ERR_W=8 and ERR_W=2) with identical
// stimulus. A position-based model of the LFSR stream predicts every output,
// and hand-computed literals pin the directed scenarios.
module tb_lfsr5_checker;

    logic       clk = 1'b0;
    logic       preset;
    logic       in_valid;
    logic [4:0] in_data;
`ifdef LFSR5_CHK_CLR_EN
    logic       err_clr;
`endif
    logic       locked_a, err_a, zero_a;
    logic [7:0] cnt_a;
    logic       locked_b, err_b, zero_b;
    logic [1:0] cnt_b;

    int ntests = 0;
    int nfail  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    lfsr5_checker #(.LOCK_CNT(4), .UNLOCK_ERRS(3), .ERR_W(8)) dut_a (
        .clk(clk), .preset(preset),
`ifdef LFSR5_CHK_CLR_EN
        .err_clr(err_clr),
`endif
        .in_valid(in_valid), .in_data(in_data),
        .locked(locked_a), .err(err_a), .zero_seen(zero_a), .err_count(cnt_a)
    );

    lfsr5_checker #(.LOCK_CNT(4), .UNLOCK_ERRS(3), .ERR_W(2)) dut_b (
        .clk(clk), .preset(preset),
`ifdef LFSR5_CHK_CLR_EN
        .err_clr(err_clr),
`endif
        .in_valid(in_valid), .in_data(in_data),
        .locked(locked_b), .err(err_b), .zero_seen(zero_b), .err_count(cnt_b)
    );

    // Stream table: tab[i] is the i-th word after 11111, pos_of inverts it
    logic [4:0] tab [31];
    int         pos_of [32];

    task automatic chk(input string name, input int act, input int req);
        ntests++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: tracks the reference as a position in the stream
    int m_mode = 0;  // 0 hunting, 1 synchronising, 2 locked
    int m_pos  = 0;
    int m_run  = 0;
    int m_miss = 0;
    bit m_err  = 0;
    bit m_zero = 0;
    int m_cnt8 = 0;
    int m_cnt2 = 0;

    always @(posedge clk) begin
        if (preset) begin
            m_mode = 0; m_pos = 0; m_run = 0; m_miss = 0;
            m_err = 0; m_zero = 0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            m_err  = 0;
            m_zero = 0;
            if (in_valid) begin
                if (m_mode == 0) begin
                    if (in_data == 0) m_zero = 1;
                    else begin m_pos = pos_of[in_data]; m_run = 0; m_mode = 1; end
                end else if (m_mode == 1) begin
                    if (in_data == 0) begin m_zero = 1; m_mode = 0; end
                    else if (pos_of[in_data] == (m_pos + 1) % 31) begin
                        m_pos = pos_of[in_data];
                        m_run++;
                        if (m_run == 4) begin m_mode = 2; m_miss = 0; end
                    end else begin
                        m_pos = pos_of[in_data];
                        m_run = 0;
                    end
                end else begin
                    m_pos = (m_pos + 1) % 31;
                    if (in_data == tab[m_pos]) m_miss = 0;
                    else begin
                        m_err = 1;
                        m_zero = (in_data == 0);
                        if (m_cnt8 < 255) m_cnt8++;
                        if (m_cnt2 < 3) m_cnt2++;
                        m_miss++;
                        if (m_miss == 3) m_mode = 0;
                    end
                end
            end
`ifdef LFSR5_CHK_CLR_EN
            if (err_clr) begin m_cnt8 = 0; m_cnt2 = 0; end
`endif
        end
    end

    // Compare both DUTs against the model away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("locked_a", int'(locked_a), int'(m_mode == 2));
            chk("err_a", int'(err_a), int'(m_err));
            chk("zero_a", int'(zero_a), int'(m_zero));
            chk("cnt_a", int'(cnt_a), m_cnt8);
            chk("locked_b", int'(locked_b), int'(m_mode == 2));
            chk("err_b", int'(err_b), int'(m_err));
            chk("zero_b", int'(zero_b), int'(m_zero));
            chk("cnt_b", int'(cnt_b), m_cnt2);
        end
    end

    int p = 0;

    task automatic send(input logic v, input logic [4:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic send_good();
        send(1'b1, tab[p % 31]);
        p++;
    endtask

    task automatic send_bad(input logic [4:0] flip);
        send(1'b1, tab[p % 31] ^ flip);
        p++;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_preset();
        @(negedge clk);
        preset   = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        preset   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] t;
        int r;
        t = 5'b11111;
        for (int i = 0; i < 32; i++) pos_of[i] = -1;
        for (int i = 0; i < 31; i++) begin
            tab[i] = t;
            pos_of[t] = i;
            t = {t[2] ^ t[0], t[4:1]};
        end

        preset = 1'b1; in_valid = 1'b0; in_data = 5'd0;
`ifdef LFSR5_CHK_CLR_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", int'(locked_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_zero", int'(zero_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk_en = 1'b1;
        @(negedge clk);
        preset = 1'b0;

        // Clean lock on 11111 01111 00111 00011 10001
        p = 0;
        repeat (4) send_good();
        sample();
        chk("pre_lock", int'(locked_a), 0);
        send_good();
        sample();
        chk("lock_word5", int'(locked_a), 1);
        chk("lit_word4", int'(tab[4]), 5'b10001);
        repeat (62) send_good();
        sample();
        chk("clean_locked", int'(locked_a), 1);
        chk("clean_cnt", int'(cnt_a), 0);

        // Single corruption of 11000 into 11001
        for (int i = 0; i < 31 && tab[p % 31] != 5'b11000; i++) send_good();
        send_bad(5'b00001);
        sample();
        chk("corrupt_err", int'(err_a), 1);
        chk("corrupt_cnt", int'(cnt_a), 1);
        chk("lit_after", int'(tab[p % 31]), 5'b01100);
        send_good();
        sample();
        chk("after_err", int'(err_a), 0);
        chk("after_locked", int'(locked_a), 1);

        // Three consecutive errors drop lock, then five good words re-lock
        send_bad(5'b10000);
        send_bad(5'b10000);
        sample();
        chk("unlock_hold", int'(locked_a), 1);
        send_bad(5'b10000);
        sample();
        chk("unlock_locked", int'(locked_a), 0);
        chk("unlock_cnt8", int'(cnt_a), 4);
        chk("unlock_cnt2", int'(cnt_b), 3);
        repeat (5) send_good();
        sample();
        chk("relock", int'(locked_a), 1);

        // Zero words in each state
        do_preset();
        send(1'b1, 5'd0);
        sample();
        chk("hunt_zero", int'(zero_a), 1);
        chk("hunt_zero_err", int'(err_a), 0);
        send(1'b1, 5'b11111);
        send(1'b1, 5'd0);
        sample();
        chk("sync_zero", int'(zero_a), 1);
        p = 0;
        repeat (5) send_good();
        sample();
        chk("zero_relock", int'(locked_a), 1);
        send(1'b1, 5'd0);
        p++;
        sample();
        chk("lock_zero_err", int'(err_a), 1);
        chk("lock_zero_zs", int'(zero_a), 1);

        // Preset mid-lock with a valid word present
        @(negedge clk);
        preset = 1'b1; in_valid = 1'b1; in_data = tab[p % 31];
        sample();
        chk("mid_rst_locked", int'(locked_a), 0);
        chk("mid_rst_cnt", int'(cnt_a), 0);
        chk("mid_rst_err", int'(err_a), 0);
        @(negedge clk);
        preset = 1'b0; in_valid = 1'b0;

        // Gaps do not disturb lock; five errors (max two in a row) saturate ERR_W=2
        p = 7;
        repeat (5) send_good();
        for (int i = 0; i < 20; i++) begin
            send_good();
            send(1'b0, 5'd0);
        end
        sample();
        chk("gap_locked", int'(locked_a), 1);
        send_bad(5'b00100); send(1'b0, 5'd0); send_bad(5'b00100); send_good();
        send_bad(5'b00100); send_bad(5'b00100); send_good();
        send_bad(5'b00100);
        sample();
        chk("sat_cnt2", int'(cnt_b), 3);
        chk("sat_err_b", int'(err_b), 1);
        chk("sat_cnt8", int'(cnt_a), 5);
        chk("sat_locked", int'(locked_a), 1);

`ifdef LFSR5_CHK_CLR_EN
        // Clear coincident with an error
        @(negedge clk);
        err_clr = 1'b1; in_valid = 1'b1; in_data = tab[p % 31] ^ 5'b00010;
        p++;
        sample();
        chk("clr_err", int'(err_a), 1);
        chk("clr_cnt", int'(cnt_a), 0);
        @(negedge clk);
        err_clr = 1'b0; in_valid = 1'b0;
`endif

        // Randomised stream with corruption, zeros, gaps, jumps and resets
        do_preset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
`ifdef LFSR5_CHK_CLR_EN
            err_clr = ($urandom_range(0, 29) == 0);
`endif
            if (r < 3) do_preset();
            else if (r < 120) send(1'b0, 5'($urandom));
            else if (r < 150) begin send(1'b1, 5'd0); p++; end
            else if (r < 220) send_bad(5'($urandom_range(1, 31)));
            else if (r < 235) begin p = $urandom_range(0, 30); send_good(); end
            else send_good();
        end
        @(negedge clk);
        in_valid = 1'b0;
`ifdef LFSR5_CHK_CLR_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/lfsr5_checker.md
# lfsr5_checker

Receive-side sequence checker for the 5-bit maximal-length LFSR stream used across the ReactionTimer design. The LFSR uses the recurrence next(p) = {p[2]^p[0], p[4:1]}, with period 31, and all-zero is illegal. This block accepts one 5-bit word per valid cycle and self-synchronises to the stream. It then flags every word that breaks the recurrence, keeps a saturating error count, and drops lock after repeated consecutive errors. It is the consumer/verifier end of the generator: it proves a random stream is intact before the timer logic trusts it.

## Interface
- LOCK_CNT, default 4: consecutive correct successor words needed to declare lock (1..15).
- UNLOCK_ERRS, default 3: consecutive mismatches while locked that force loss of lock (1..15).
- ERR_W, default 8: width of the error counter.

- clk  in  1  rising-edge clock; the only clock.
- preset  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data carries a word this cycle.
- in_data  in  5  received LFSR word.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse per mismatched or zero word while LOCKED.
- zero_seen  out  1  one-cycle pulse per all-zero word, in any state.
- err_count  out  ERR_W  count of err pulses; saturates at all-ones.

## Operation
- next(p) = {p[2]^p[0], p[4:1]}. Internal register exp[4:0] holds the last reference word; run[3:0] and miss[3:0] are counters. All words are ignored when in_valid=0: state and counters hold.
- State HUNT:
  - Valid nonzero word: exp <= word, run <= 0, go to SYNC.
  - Valid zero word: stay in HUNT and pulse zero_seen.
- State SYNC:
  - Valid word == next(exp): exp <= word and run <= run+1. When run+1 == LOCK_CNT, go to LOCKED with miss <= 0.
  - Valid word != next(exp) and nonzero: reseed with exp <= word and run <= 0; stay in SYNC.
  - Valid zero word: go to HUNT and pulse zero_seen.
- State LOCKED: exp <= next(exp) on every valid word. Prediction comes from the expected word, not the received one, so a single corrupted word produces exactly one error.
  - Match: miss <= 0.
  - Mismatch, including a zero word: err pulse, err_count++ (saturating), miss <= miss+1. When miss+1 == UNLOCK_ERRS, go to HUNT. A zero word also pulses zero_seen.
- err is never asserted outside LOCKED. err_count is not cleared by loss of lock.

## Timing
- Reset (preset=1 at a clock edge): state=HUNT, exp=5'b11111, run=0, miss=0, locked=0, err=0, zero_seen=0, err_count=0. Reset takes priority over in_valid.
- All outputs are registered.
  - err, zero_seen and the err_count update appear the cycle after the offending valid word.
  - locked rises the cycle after the LOCK_CNT-th matching word, so the earliest is LOCK_CNT+1 valid words after reset.
  - locked falls the cycle after the UNLOCK_ERRS-th consecutive mismatch.
- Back-to-back valid words, one per cycle, are accepted with no stalls. There is no backpressure.
- At saturation (count all-ones), a further error still pulses err, and err_count holds.
- Preset asserted mid-stream fully restarts acquisition. Partial lock state is not kept.

## Configuration
- LFSR5_CHK_CLR_EN defined:
  - Adds input port err_clr (1 bit). When err_clr=1, err_count <= 0 on that edge.
  - If an error occurs in the same cycle, the clear wins and the error is not counted; err still pulses.
  - state, locked, exp, run and miss are unaffected.
- LFSR5_CHK_CLR_EN undefined: there is no err_clr port, and err_count clears only on preset.

## Test plan
- Clean lock: after preset, feed 11111, 01111, 00111, 00011, 10001 on consecutive cycles with LOCK_CNT=4. Required: locked=1 the cycle after 10001, err never asserts, and continuing the sequence for 62 words keeps locked=1 with err_count=0.
- Single corruption: while locked, replace the expected word 11000 with 11001. Required: exactly one err pulse, err_count=1, and the next correct word 01100 is accepted without error.
- Unlock: while locked, inject 3 consecutive wrong words with UNLOCK_ERRS=3. Required: err_count +3 and locked=0 the cycle after the third; then re-acquisition after 5 good words.
- Zero handling: in HUNT, a 00000 word pulses zero_seen and the block stays in HUNT. In SYNC, a zero word returns the block to HUNT. In LOCKED, a zero word pulses both err and zero_seen.
- Gaps and saturation: with ERR_W=2, in_valid toggling 1/0 does not affect lock. With 5 errors at most 2 consecutive, err_count=3 and holds.
- Reset and clear: preset mid-lock gives all outputs at reset values next cycle. With LFSR5_CHK_CLR_EN, err_clr coincident with an error gives err_count=0 and err=1.
